// File: rtl/muldiv6_pkg.sv
// Shared definitions for the muldiv6 command sequencer: FSM states, op bits, flags.
package muldiv6_pkg;

    typedef enum logic [2:0] {
        ST_OP,
        ST_LD_A,
        ST_LD_B,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT_HI,
        ST_OUT_LO
    } state_t;

    localparam int OP_DIV    = 0;
    localparam int OP_SIGNED = 1;

    localparam logic [1:0] FLG_OK   = 2'b00;
    localparam logic [1:0] FLG_TMO  = 2'b01;
    localparam logic [1:0] FLG_DIV0 = 2'b10;

endpackage

// File: rtl/muldiv6_cmd_seq.sv
// Byte-stream command sequencer for the muldiv6 core (op, a, b in; hi/lo result bytes out).
// Optional MULDIV6_DIV0_CHECK_EN: short-circuit divide-by-zero without issuing to the core.
module muldiv6_cmd_seq
    import muldiv6_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             core_valid,
    input  logic             core_ready,
    output logic [1:0]       core_op,
    output logic [OPW-1:0]   core_a,
    output logic [OPW-1:0]   core_b,
    input  logic             core_done,
    input  logic [2*OPW-1:0] core_result,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           state, state_nx;
    logic [1:0]       op;
    logic [OPW-1:0]   a, b;
    logic [2*OPW-1:0] result;
    logic [1:0]       flags;
    logic [CW-1:0]    cnt;

    logic in_fire, div0, tmo;

    assign in_fire = in_valid && in_ready;
    // Last permitted WAIT cycle; core_done on this cycle still wins.
    assign tmo     = (cnt == CW'(TIMEOUT - 1));

`ifdef MULDIV6_DIV0_CHECK_EN
    assign div0 = op[OP_DIV] && (in_data[OPW-1:0] == '0);
`else
    assign div0 = 1'b0;
`endif

    assign core_op = op;
    assign core_a  = a;
    assign core_b  = b;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_OP;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        core_valid = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        case (state)
            ST_OP: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ST_LD_A;
            end
            ST_LD_A: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ST_LD_B;
            end
            ST_LD_B: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = div0 ? ST_OUT_HI : ST_ISSUE;
            end
            ST_ISSUE: begin
                core_valid = 1'b1;
                if (core_ready) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done || tmo) state_nx = ST_OUT_HI;
            end
            ST_OUT_HI: begin
                out_valid = 1'b1;
                out_data  = {flags, 6'(result[2*OPW-1:OPW])};
                if (out_ready) state_nx = ST_OUT_LO;
            end
            ST_OUT_LO: begin
                out_valid = 1'b1;
                out_data  = {2'b00, 6'(result[OPW-1:0])};
                if (out_ready) state_nx = ST_OP;
            end
            default: state_nx = ST_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= '0;
            a      <= '0;
            b      <= '0;
            result <= '0;
            flags  <= FLG_OK;
            cnt    <= '0;
        end else begin
            case (state)
                ST_OP:    if (in_fire) op <= in_data[1:0];
                ST_LD_A:  if (in_fire) a <= in_data[OPW-1:0];
                ST_LD_B: begin
                    if (in_fire) begin
                        b <= in_data[OPW-1:0];
                        if (div0) begin
                            result <= '1;
                            flags  <= FLG_DIV0;
                        end
                    end
                end
                ST_ISSUE: cnt <= '0;
                ST_WAIT: begin
                    if (core_done) begin
                        result <= core_result;
                        flags  <= FLG_OK;
                    end else if (tmo) begin
                        result <= '0;
                        flags  <= FLG_TMO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv6_cmd_seq.sv
// Directed, table-driven bench for muldiv6_cmd_seq with hand-written corner sequences.
module tb_muldiv6_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        core_valid;
    logic        core_ready;
    logic [1:0]  core_op;
    logic [5:0]  core_a, core_b;
    logic        core_done;
    logic [11:0] core_result;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int total = 0;
    int bad   = 0;
    int cv_seen = 0;

    muldiv6_cmd_seq #(.OPW(6), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_valid(core_valid), .core_ready(core_ready), .core_op(core_op),
        .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (core_valid) cv_seen++;

    typedef struct {
        logic [7:0]  op, a, b;
        logic [1:0]  eop;
        logic [5:0]  ea, eb;
        int          dly;
        logic [11:0] res;
        logic [7:0]  hi, lo;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] o, input logic [7:0] x, input logic [7:0] y);
        send_byte(o);
        send_byte(x);
        send_byte(y);
    endtask

    // Waits for core_valid at a negedge; leaves time at that negedge.
    task automatic wait_core(input string name);
        int n = 0;
        @(negedge clk);
        while (!core_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_core_valid"}, 32'(core_valid), 1);
    endtask

    task automatic handshake();
        core_ready = 1'b1;
        @(posedge clk); #1;
        core_ready = 1'b0;
    endtask

    task automatic finish_core(input int dly, input logic [11:0] res);
        for (int i = 0; i < dly; i++) @(negedge clk);
        @(negedge clk);
        core_done   = 1'b1;
        core_result = res;
        @(posedge clk); #1;
        core_done   = 1'b0;
    endtask

    task automatic recv_byte(input string name, input logic [7:0] exp, output int waited);
        waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk({name, "_valid"}, 32'(out_valid), 1);
        chk({name, "_data"}, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int w;
        int snap;
        logic [5:0] a_hold;

        tbl[0] = '{8'h00, 8'h05, 8'h07, 2'd0, 6'h05, 6'h07, 0,  12'h023, 8'h00, 8'h23};
        tbl[1] = '{8'h00, 8'h3F, 8'h3F, 2'd0, 6'h3F, 6'h3F, 3,  12'hF81, 8'h3E, 8'h01};
        tbl[2] = '{8'h01, 8'h2D, 8'h07, 2'd1, 6'h2D, 6'h07, 5,  12'h183, 8'h06, 8'h03};
        tbl[3] = '{8'hFF, 8'hEA, 8'h7B, 2'd3, 6'h2A, 6'h3B, 1,  12'hABC, 8'h2A, 8'h3C};
        // done lands on the last permitted WAIT cycle: normal result wins
        tbl[4] = '{8'h02, 8'h3F, 8'h01, 2'd2, 6'h3F, 6'h01, 63, 12'h555, 8'h15, 8'h15};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; core_ready = 1'b0;
        core_done = 1'b0; core_result = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_core_valid", 32'(core_valid), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_operands", {core_op, core_a, core_b}, 0);

        for (int i = 0; i < 5; i++) begin
            send_cmd(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_core($sformatf("v%0d", i));
            chk($sformatf("v%0d_core_op", i), 32'(core_op), 32'(tbl[i].eop));
            chk($sformatf("v%0d_core_a", i), 32'(core_a), 32'(tbl[i].ea));
            chk($sformatf("v%0d_core_b", i), 32'(core_b), 32'(tbl[i].eb));
            handshake();
            finish_core(tbl[i].dly, tbl[i].res);
            recv_byte($sformatf("v%0d_hi", i), tbl[i].hi, w);
            chk($sformatf("v%0d_latency", i), w, 0);
            recv_byte($sformatf("v%0d_lo", i), tbl[i].lo, w);
        end

        // ISSUE holds operands under core_ready=0; stray core_done is ignored
        send_cmd(8'h00, 8'h11, 8'h22);
        wait_core("hold");
        a_hold = core_a;
        core_done = 1'b1; core_result = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_core_valid", 32'(core_valid), 1);
            chk("hold_core_a", 32'(core_a), 32'(a_hold));
        end
        core_done = 1'b0;
        handshake();
        finish_core(2, 12'h2C3);
        recv_byte("hold_hi", 8'h0B, w);
        // core_done during OUT_LO must not disturb the held result
        core_done = 1'b1; core_result = 12'hFFF;
        recv_byte("hold_lo", 8'h03, w);
        core_done = 1'b0;

        // divide by zero
        snap = cv_seen;
        send_cmd(8'h01, 8'h2D, 8'h00);
`ifdef MULDIV6_DIV0_CHECK_EN
        recv_byte("div0_hi", 8'hBF, w);
        recv_byte("div0_lo", 8'h3F, w);
        chk("div0_no_issue", cv_seen - snap, 0);
`else
        wait_core("div0");
        chk("div0_core_b", 32'(core_b), 0);
        handshake();
        finish_core(0, 12'hB40);
        recv_byte("div0_hi", 8'h2D, w);
        recv_byte("div0_lo", 8'h00, w);
`endif

        // timeout: core never completes
        send_cmd(8'h00, 8'h01, 8'h02);
        wait_core("tmo");
        handshake();
        recv_byte("tmo_hi", 8'h40, w);
        chk("tmo_wait_cycles", w, 64);
        recv_byte("tmo_lo", 8'h00, w);
        send_cmd(8'h00, 8'h03, 8'h04);
        wait_core("after_tmo");
        chk("after_tmo_core_a", 32'(core_a), 3);
        handshake();
        finish_core(0, 12'h00C);
        recv_byte("after_tmo_hi", 8'h00, w);
        recv_byte("after_tmo_lo", 8'h0C, w);

        // reset during WAIT aborts with no output
        send_cmd(8'h00, 8'h05, 8'h06);
        wait_core("rst_wait");
        handshake();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_in_ready", 32'(in_ready), 1);
        chk("rstw_out_valid", 32'(out_valid), 0);
        chk("rstw_core_valid", 32'(core_valid), 0);
        chk("rstw_out_data", 32'(out_data), 0);
        core_done = 1'b1; core_result = 12'h123;
        @(negedge clk);
        core_done = 1'b0;
        snap = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) snap++;
        end
        chk("rstw_no_output", snap, 0);

        // back-pressure: out_data stable while stalled in OUT_HI
        send_cmd(8'h00, 8'h09, 8'h0A);
        wait_core("bp");
        handshake();
        finish_core(1, 12'h9D5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_stall%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("bp_stall%0d_data", i), 32'(out_data), 32'h27);
        end
        recv_byte("bp_hi", 8'h27, w);
        recv_byte("bp_lo", 8'h15, w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
